irq_req_latch: RTL and testbench
================================

# irq_req_latch

Interrupt request collector that sits directly upstream of the 8-to-3 priority encoder. It synchronises eight asynchronous request lines and detects rising edges. Each edge is latched into a pending register, and the masked pending vector is presented to the encoder. The encoder's 3-bit code is returned to this block, which presents it to the consumer with a valid/ack handshake and clears the serviced bit on ack.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth per request line before edge detection; legal values 2..3.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  asynchronous request lines; a rising edge raises a request.
- mask  in  8  synchronous enable per line; 1 = line may be presented.
- pend  out  8  registered `pending & mask`; drives the priority encoder input.
- enc_idx  in  3  combinational encoder code for the current `pend`.
- irq_valid  out  1  a serviced index is being offered.
- irq_idx  out  3  index offered; stable while `irq_valid` is high.
- irq_ack  in  1  consumer accepts `irq_idx`; only meaningful while `irq_valid` is high.

## Operation
- Per line:
  - SYNC_STAGES flops, then one history flop.
  - Rise = last sync stage & ~history.
  - A rise sets `pending[i]`.
  - Level-held requests raise exactly one event.
- `pending` is kept regardless of `mask`. Masked bits stay latched and appear on `pend` when unmasked.
- `pend` <= `pending & mask` every cycle.
- FSM states:
  - IDLE: if `pend != 0`, capture `enc_idx` into `irq_idx`, set `irq_valid`, go to OFFER.
  - OFFER: hold `irq_valid` and `irq_idx`. On `irq_ack`:
    - clear `pending[irq_idx]`
    - drop `irq_valid`
    - go to SETTLE.
  - SETTLE: one cycle so `pend` reflects the clear; then go to IDLE.
- Boundary rules:
  - **Set and clear on the same bit in the same cycle:** set wins; the new event is not lost.
  - **Mask cleared during OFFER:** the offer is not retracted; it completes on ack.
  - **`irq_ack` outside OFFER:** ignored.
  - **`pend == 0` in IDLE:** no offer; `irq_idx` holds its last value.
  - **`enc_idx` while `pend == 0`:** ignored.
- Reset (any time, including mid-OFFER):
  - Clears sync/history flops, `pending`, `pend`, `irq_valid` and `irq_idx` (all 0); state = IDLE.
  - A line already high at reset release counts as one rising edge.

## Timing
Cycle counts below are for SYNC_STAGES = 2; add 1 to each for SYNC_STAGES = 3.
- `req[i]` first sampled high at edge E:
  - `pending[i]` = 1 after E+2
  - `pend[i]` = 1 after E+3
  - `irq_valid` = 1 after E+4, when IDLE and unmasked.
- `irq_ack` sampled at edge A:
  - `irq_valid` = 0 and `pending` bit cleared after A.
  - `pend` updated after A+1.
  - Earliest next `irq_valid` is after A+2.
  - Throughput is one service per 3 cycles minimum (ack same cycle as offer).
- `irq_idx` is registered; it changes only on the IDLE->OFFER transition.
- `enc_idx` is sampled only in IDLE.

## Structure
- Shared package `irq_pkg`:
  - `N_REQ = 8`
  - `IDX_W = 3`
  - FSM state typedef {IDLE, OFFER, SETTLE}
- Sub-module `sync_rise_det`: one line; SYNC_STAGES synchroniser plus history flop, one-cycle rise pulse, async reset to 0. Instantiate it 8 times.
- The priority encoder stays external; `pend` / `enc_idx` cross the block boundary.

## Test plan
- **Single request:** reset, mask = 8'hFF; pulse `req[5]` high 4 cycles -> `pend` = 8'h20 at E+3; `irq_valid` = 1, `irq_idx` = 5 at E+4; ack -> `pend` = 8'h00, no further offer.
- **Priority order:** raise `req[2]` and `req[6]` in the same cycle, with the encoder model attached -> offers idx 6, then after ack idx 2, exactly 3 cycles apart when ack is immediate.
- **Masking:** mask = 8'hEF; pulse `req[4]` -> no offer and `pend` = 0; then set mask = 8'hFF -> offer idx 4 two cycles later.
- **Re-arm during offer:** `req[3]` offered; during OFFER, drop and re-raise `req[3]` so its rise coincides with the ack cycle -> `pending[3]` stays 1 and idx 3 is offered again after SETTLE.
- **Reset mid-offer:** assert `rst` while `irq_valid` = 1 with `req` lines held at 8'h00 -> all outputs 0 asynchronously; no offer after release. Repeat with `req[1]` held high -> exactly one offer of idx 1 after release.
- **Spurious ack / level hold:** `irq_ack` pulsed in IDLE -> no state change; `req[0]` held high 50 cycles -> exactly one offer of idx 0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request collector.
package irq_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    SETTLE = 2'd2
  } irq_state_e;

  // One-hot mask selecting the request line named by idx.
  function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// One request line: multi-flop synchroniser, history flop and a one-cycle
// rise pulse. A line already high when reset releases yields one pulse,
// because the history flop starts at 0.
module sync_rise_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;

  // Shift the raw line through the synchroniser; history trails the last stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_in};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and history registers, cleared to 0 on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_req_latch.sv
// Interrupt request collector: latches rising edges of eight async request
// lines, presents the masked pending vector to an external priority encoder,
// and offers the returned index to a consumer over a valid/ack handshake.
module irq_req_latch
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] pend,
  input  logic [IDX_W-1:0] enc_idx,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  input  logic             irq_ack
);

  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] clr;
  irq_state_e       state_q, state_d;
  logic             irq_valid_q, irq_valid_d;
  logic [IDX_W-1:0] irq_idx_q, irq_idx_d;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_line
      sync_rise_det #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_det (
        .clk   (clk),
        .rst   (rst),
        .req_in(req[gi]),
        .rise  (rise[gi])
      );
    end
  endgenerate

  // Offer FSM: capture the encoder code in IDLE, hold it until ack, then
  // spend one cycle letting pend reflect the cleared bit.
  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_idx_d   = irq_idx_q;
    clr         = '0;
    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          irq_idx_d   = enc_idx;
          irq_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (irq_ack) begin
          clr         = idx_onehot(irq_idx_q);
          irq_valid_d = 1'b0;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        irq_valid_d = 1'b0;
      end
    endcase
  end

  // Pending update: a new rise on the bit being cleared wins, so no event is lost.
  // Mask only gates the presented copy; latched bits survive while masked.
  always_comb begin
    pending_d = (pending_q & ~clr) | rise;
    pend_d    = pending_q & mask;
  end

  // State, pending and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      pend_q      <= '0;
      irq_valid_q <= 1'b0;
      irq_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pend_q      <= pend_d;
      irq_valid_q <= irq_valid_d;
      irq_idx_q   <= irq_idx_d;
    end
  end

  assign pend      = pend_q;
  assign irq_valid = irq_valid_q;
  assign irq_idx   = irq_idx_q;

endmodule

// File: tb/tb_irq_req_latch.sv
// Directed bench for irq_req_latch with an attached highest-index-wins
// encoder model that returns a junk code whenever pend is zero.
module tb_irq_req_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic [7:0] pend;
  logic [2:0] enc_idx;
  logic       irq_valid;
  logic [2:0] irq_idx;
  logic       irq_ack;

  int checks   = 0;
  int failures = 0;

  irq_req_latch #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .mask     (mask),
    .pend     (pend),
    .enc_idx  (enc_idx),
    .irq_valid(irq_valid),
    .irq_idx  (irq_idx),
    .irq_ack  (irq_ack)
  );

  always #5 clk = ~clk;

  // Encoder model: highest set bit wins; 7 while idle so stray codes show up.
  always_comb begin
    enc_idx = 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (pend[i]) enc_idx = 3'(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = 8'h00; irq_ack = 1'b0; mask = 8'hFF;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00; irq_ack = 1'b0; mask = 8'hFF;
    tick(); tick();
    checks++; if (pend !== 8'h00) begin failures++; $display("FAIL reset_pend got=%h exp=00", pend); end
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", irq_valid); end
    checks++; if (irq_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", irq_idx); end
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    int n;
    apply_reset();
    req = 8'h20;
    tick();                       // E
    tick();                       // E+1
    checks++; if (pend !== 8'h00) begin failures++; $display("FAIL single_pend_e1 got=%h exp=00", pend); end
    tick();                       // E+2
    checks++; if (pend !== 8'h00) begin failures++; $display("FAIL single_pend_e2 got=%h exp=00", pend); end
    tick();                       // E+3
    req = 8'h00;
    checks++; if (pend !== 8'h20) begin failures++; $display("FAIL single_pend_e3 got=%h exp=20", pend); end
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL single_valid_e3 got=%b exp=0", irq_valid); end
    tick();                       // E+4
    checks++; if (irq_valid !== 1'b1) begin failures++; $display("FAIL single_valid_e4 got=%b exp=1", irq_valid); end
    checks++; if (irq_idx !== 3'd5) begin failures++; $display("FAIL single_idx got=%0d exp=5", irq_idx); end
    tick();                       // held offer, no ack yet
    checks++; if (irq_valid !== 1'b1 || irq_idx !== 3'd5) begin failures++; $display("FAIL single_hold got=%b/%0d exp=1/5", irq_valid, irq_idx); end
    irq_ack = 1'b1;
    tick();                       // A
    irq_ack = 1'b0;
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL single_valid_ack got=%b exp=0", irq_valid); end
    tick();                       // A+1
    checks++; if (pend !== 8'h00) begin failures++; $display("FAIL single_pend_clr got=%h exp=00", pend); end
    n = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (irq_valid) n++; end
    checks++; if (n !== 0) begin failures++; $display("FAIL single_no_reoffer got=%0d exp=0", n); end
    $display("test_single done");
  endtask

  task automatic test_priority();
    apply_reset();
    req = 8'h44;
    repeat (4) tick();            // E..E+3
    req = 8'h00;
    tick();                       // E+4
    checks++; if (irq_valid !== 1'b1 || irq_idx !== 3'd6) begin failures++; $display("FAIL prio_first got=%b/%0d exp=1/6", irq_valid, irq_idx); end
    irq_ack = 1'b1;
    tick();                       // A
    irq_ack = 1'b0;
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL prio_drop got=%b exp=0", irq_valid); end
    tick();                       // A+1
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL prio_settle got=%b exp=0", irq_valid); end
    checks++; if (pend !== 8'h04) begin failures++; $display("FAIL prio_pend got=%h exp=04", pend); end
    tick();                       // A+2
    checks++; if (irq_valid !== 1'b1 || irq_idx !== 3'd2) begin failures++; $display("FAIL prio_second got=%b/%0d exp=1/2", irq_valid, irq_idx); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick(); tick();
    checks++; if (irq_valid !== 1'b0 || pend !== 8'h00) begin failures++; $display("FAIL prio_done got=%b/%h exp=0/00", irq_valid, pend); end
    $display("test_priority done");
  endtask

  task automatic test_masking();
    apply_reset();
    mask = 8'hEF;
    req  = 8'h10;
    repeat (4) tick();
    req = 8'h00;
    repeat (4) tick();
    checks++; if (pend !== 8'h00 || irq_valid !== 1'b0) begin failures++; $display("FAIL mask_block got=%h/%b exp=00/0", pend, irq_valid); end
    mask = 8'hFF;
    tick();
    checks++; if (pend !== 8'h10 || irq_valid !== 1'b0) begin failures++; $display("FAIL mask_pend got=%h/%b exp=10/0", pend, irq_valid); end
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_idx !== 3'd4) begin failures++; $display("FAIL mask_offer got=%b/%0d exp=1/4", irq_valid, irq_idx); end
    mask = 8'h00;                 // masking mid-offer must not retract it
    tick(); tick();
    checks++; if (irq_valid !== 1'b1 || irq_idx !== 3'd4 || pend !== 8'h00) begin failures++; $display("FAIL mask_offer_kept got=%b/%0d/%h exp=1/4/00", irq_valid, irq_idx, pend); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    mask = 8'hFF;
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL mask_ack got=%b exp=0", irq_valid); end
    repeat (3) tick();
    checks++; if (pend !== 8'h00 || irq_valid !== 1'b0) begin failures++; $display("FAIL mask_cleared got=%h/%b exp=00/0", pend, irq_valid); end
    $display("test_masking done");
  endtask

  task automatic test_rearm();
    apply_reset();
    req = 8'h08;
    repeat (4) tick();            // E..E+3
    tick();                       // E+4
    checks++; if (irq_valid !== 1'b1 || irq_idx !== 3'd3) begin failures++; $display("FAIL rearm_first got=%b/%0d exp=1/3", irq_valid, irq_idx); end
    req = 8'h00;
    tick();                       // E+5: low sampled
    req = 8'h08;
    tick();                       // E+6: high sampled again
    tick();                       // E+7
    irq_ack = 1'b1;
    tick();                       // E+8: ack and rise coincide
    irq_ack = 1'b0;
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL rearm_drop got=%b exp=0", irq_valid); end
    tick();
    checks++; if (pend !== 8'h08) begin failures++; $display("FAIL rearm_pend got=%h exp=08", pend); end
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_idx !== 3'd3) begin failures++; $display("FAIL rearm_second got=%b/%0d exp=1/3", irq_valid, irq_idx); end
    req = 8'h00;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    repeat (5) tick();
    checks++; if (irq_valid !== 1'b0 || pend !== 8'h00) begin failures++; $display("FAIL rearm_done got=%b/%h exp=0/00", irq_valid, pend); end
    $display("test_rearm done");
  endtask

  task automatic test_reset_mid_offer();
    int offers;
    logic [2:0] seen;
    // Part 1: lines low through reset.
    apply_reset();
    req = 8'h20;
    repeat (4) tick();
    req = 8'h00;
    tick();
    checks++; if (irq_valid !== 1'b1) begin failures++; $display("FAIL rmid_setup got=%b exp=1", irq_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (irq_valid !== 1'b0 || pend !== 8'h00 || irq_idx !== 3'd0) begin failures++; $display("FAIL rmid_async got=%b/%h/%0d exp=0/00/0", irq_valid, pend, irq_idx); end
    tick(); tick();
    rst = 1'b0;
    offers = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (irq_valid) offers++; end
    checks++; if (offers !== 0) begin failures++; $display("FAIL rmid_quiet got=%0d exp=0", offers); end
    // Part 2: req[1] held high through reset counts as one edge.
    apply_reset();
    req = 8'h02;
    repeat (5) tick();
    checks++; if (irq_valid !== 1'b1 || irq_idx !== 3'd1) begin failures++; $display("FAIL rmid_setup2 got=%b/%0d exp=1/1", irq_valid, irq_idx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL rmid_async2 got=%b exp=0", irq_valid); end
    tick(); tick();
    rst = 1'b0;
    offers = 0;
    seen = 3'd0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (irq_valid && !irq_ack) begin offers++; seen = irq_idx; irq_ack = 1'b1; end
      else irq_ack = 1'b0;
    end
    irq_ack = 1'b0;
    req = 8'h00;
    checks++; if (offers !== 1) begin failures++; $display("FAIL rmid_held_count got=%0d exp=1", offers); end
    checks++; if (seen !== 3'd1) begin failures++; $display("FAIL rmid_held_idx got=%0d exp=1", seen); end
    $display("test_reset_mid_offer done");
  endtask

  task automatic test_spurious_level();
    int offers;
    logic [2:0] seen;
    apply_reset();
    req = 8'h20;
    repeat (4) tick();
    req = 8'h00;
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    repeat (3) tick();
    irq_ack = 1'b1;               // ack while idle must do nothing
    repeat (3) tick();
    irq_ack = 1'b0;
    checks++; if (irq_valid !== 1'b0 || pend !== 8'h00) begin failures++; $display("FAIL spur_idle got=%b/%h exp=0/00", irq_valid, pend); end
    checks++; if (irq_idx !== 3'd5) begin failures++; $display("FAIL spur_idx_hold got=%0d exp=5", irq_idx); end
    req = 8'h01;
    offers = 0;
    seen = 3'd7;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (irq_valid && !irq_ack) begin offers++; seen = irq_idx; irq_ack = 1'b1; end
      else irq_ack = 1'b0;
    end
    irq_ack = 1'b0;
    req = 8'h00;
    checks++; if (offers !== 1) begin failures++; $display("FAIL level_count got=%0d exp=1", offers); end
    checks++; if (seen !== 3'd0) begin failures++; $display("FAIL level_idx got=%0d exp=0", seen); end
    $display("test_spurious_level done");
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; mask = 8'hFF; irq_ack = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_rearm();
    test_reset_mid_offer();
    test_spurious_level();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
